// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and default sizes for the multi-port register file
//
// Contents:
//   rf_state_t : clear-engine state (RF_IDLE, RF_CLEAR)
//   RF_WIDTH   : default register width in bits
//   RF_DEPTH   : default number of registers

package rf_pkg;

    typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;

    localparam int RF_WIDTH = 64;
    localparam int RF_DEPTH = 32;

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one combinational read port of the register file
//
// Decodes a read address against the storage array. The hardwired zero index
// and any index >= DEPTH both read as 0. When RF_WRITE_BYPASS_EN is defined,
// a write committing in the same cycle to the same address is forwarded.
//
// Ports:
//   mem      in  DEPTH x WIDTH  storage array contents
//   rd_addr  in  ADDR_W         register index to read
//   wr_fire  in  1              a write commits at the next edge (already
//                               qualified: IDLE, in range, not ZERO_IDX)
//   wr_addr  in  ADDR_W         index of that write
//   wr_data  in  WIDTH          data of that write
//   rd_data  out WIDTH          read result
//
// Optional feature macro: RF_WRITE_BYPASS_EN

module rf_read_port
    import rf_pkg::*;
#(
    parameter  int WIDTH    = RF_WIDTH,
    parameter  int DEPTH    = RF_DEPTH,
    parameter  int ZERO_IDX = DEPTH - 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic [WIDTH-1:0]  mem [DEPTH],
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_fire,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data
);

    // One extra bit so the range compare still works when DEPTH is a power of two.
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic readable;
    assign readable = ({1'b0, rd_addr} < DEPTH_W) && (rd_addr != ADDR_W'(ZERO_IDX));

`ifdef RF_WRITE_BYPASS_EN
    // wr_fire is only high for writable addresses in IDLE, so forwarding can
    // never leak into the zero register, out-of-range reads or a clear.
    always_comb begin
        rd_data = '0;
        if (readable) begin
            if (wr_fire && (wr_addr == rd_addr)) begin
                rd_data = wr_data;
            end else begin
                rd_data = mem[rd_addr];
            end
        end
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{wr_fire, wr_addr, wr_data};

    always_comb begin
        rd_data = '0;
        if (readable) begin
            rd_data = mem[rd_addr];
        end
    end
`endif

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - parametrised 2-read/1-write register file with bulk-clear engine
//
// Storage, write port and the sequenced clear FSM live here; each read port
// is an rf_read_port instance.
//
// Ports:
//   clk        in  1       rising-edge clock
//   reset      in  1       asynchronous active-high reset
//   wr_en      in  1       write enable
//   wr_addr    in  ADDR_W  write index
//   wr_data    in  WIDTH   write data
//   rd_addr_a  in  ADDR_W  read port A index
//   rd_data_a  out WIDTH   read port A data
//   rd_addr_b  in  ADDR_W  read port B index
//   rd_data_b  out WIDTH   read port B data
//   clr_req    in  1       pulse to start a bulk clear
//   clr_busy   out 1       high for the DEPTH cycles of a clear
//   clr_done   out 1       high on the final clear cycle
//
// Optional feature macro: RF_WRITE_BYPASS_EN (same-cycle write forwarding)

module reg_file_mp
    import rf_pkg::*;
#(
    parameter  int WIDTH    = RF_WIDTH,
    parameter  int DEPTH    = RF_DEPTH,
    parameter  int ZERO_IDX = DEPTH - 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0]  mem [DEPTH];
    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              wr_fire;

    assign wr_fire = wr_en
                  && (state_q == RF_IDLE)
                  && ({1'b0, wr_addr} < DEPTH_W)
                  && (wr_addr != ADDR_W'(ZERO_IDX));

    // A write and clr_req in the same IDLE cycle both act: the write lands at
    // this edge and the clear that starts afterwards zeroes it later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state_q == RF_CLEAR) begin
            mem[cnt_q] <= '0;
        end else if (wr_fire) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RF_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Busy/done are decoded from the state register, so an asynchronous reset
    // drops them at once and a reset mid-clear never produces a done pulse.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_busy = 1'b0;
        clr_done = 1'b0;
        case (state_q)
            RF_IDLE: begin
                if (clr_req) begin
                    state_d = RF_CLEAR;
                    cnt_d   = '0;
                end
            end
            RF_CLEAR: begin
                clr_busy = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    clr_done = 1'b1;
                    state_d  = RF_IDLE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RF_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    rf_read_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_IDX (ZERO_IDX)
    ) u_port_a (
        .mem     (mem),
        .rd_addr (rd_addr_a),
        .wr_fire (wr_fire),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data_a)
    );

    rf_read_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_IDX (ZERO_IDX)
    ) u_port_b (
        .mem     (mem),
        .rd_addr (rd_addr_b),
        .wr_fire (wr_fire),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data_b)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed self-checking bench for reg_file_mp

module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [63:0] rd_data_a;
    logic [4:0]  rd_addr_b;
    logic [63:0] rd_data_b;
    logic        clr_req;
    logic        clr_busy;
    logic        clr_done;

    logic        wr_en_v;
    logic [5:0]  wr_addr_v;
    logic [63:0] wr_data_v;
    logic [5:0]  rd_addr_a_v;
    logic [63:0] rd_data_a_v;
    logic [5:0]  rd_addr_b_v;
    logic [63:0] rd_data_b_v;
    logic        clr_req_v;
    logic        clr_busy_v;
    logic        clr_done_v;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    reg_file_mp u_dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done)
    );

    reg_file_mp #(.WIDTH(64), .DEPTH(33)) u_dut33 (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en_v),
        .wr_addr   (wr_addr_v),
        .wr_data   (wr_data_v),
        .rd_addr_a (rd_addr_a_v),
        .rd_data_a (rd_data_a_v),
        .rd_addr_b (rd_addr_b_v),
        .rd_data_b (rd_data_b_v),
        .clr_req   (clr_req_v),
        .clr_busy  (clr_busy_v),
        .clr_done  (clr_done_v)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_clear(output int busy_n, output int done_cyc, output int done_n);
        busy_n   = 0;
        done_cyc = 0;
        done_n   = 0;
        clr_req  = 1'b1;
        tick();
        clr_req  = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (clr_busy) busy_n++;
            if (clr_done) begin
                done_n++;
                done_cyc = cyc;
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int busy_n, done_cyc, done_n;
        logic [63:0] exp_same;

        reset = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0; clr_req = 1'b0;
        wr_en_v = 1'b0; wr_addr_v = '0; wr_data_v = '0;
        rd_addr_a_v = '0; rd_addr_b_v = '0; clr_req_v = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_rd_x0", rd_data_a, 64'h0);
        check("reset_busy", {63'h0, clr_busy}, 64'h0);
        check("reset_done", {63'h0, clr_done}, 64'h0);
        reset = 1'b0;

        // basic writes on consecutive cycles
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h1234;
        tick();
        wr_addr = 5'd7; wr_data = 64'hDEAD_BEEF;
        tick();
        wr_en = 1'b0;
        rd_addr_a = 5'd5; rd_addr_b = 5'd7;
        #1;
        check("rd_x5", rd_data_a, 64'h1234);
        check("rd_x7", rd_data_b, 64'hDEAD_BEEF);

        // hardwired zero register
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        rd_addr_a = 5'd31;
        #1;
        check("zero_same_cycle", rd_data_a, 64'h0);
        tick();
        wr_en = 1'b0;
        #1;
        check("zero_after_write", rd_data_a, 64'h0);

        // read during write, same address
`ifdef RF_WRITE_BYPASS_EN
        exp_same = 64'hAA;
`else
        exp_same = 64'h0;
`endif
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hAA;
        rd_addr_a = 5'd3;
        #1;
        check("rdw_same_cycle", rd_data_a, exp_same);
        tick();
        wr_en = 1'b0;
        #1;
        check("rdw_next_cycle", rd_data_a, 64'hAA);

        // fill x0..x30 with index+1
        for (int i = 0; i < 31; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 64'(i + 1);
            tick();
        end
        wr_en = 1'b0;
        rd_addr_a = 5'd3; rd_addr_b = 5'd30;
        #1;
        check("fill_x3", rd_data_a, 64'd4);
        check("fill_x30", rd_data_b, 64'd31);

        // bulk clear with live reads and a dropped mid-clear write
        rd_addr_a = 5'd0;
        busy_n = 0; done_cyc = 0; done_n = 0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (clr_busy) busy_n++;
            if (clr_done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (cyc == 1) begin
                check("clr_c1_x0", rd_data_a, 64'd1);
                check("clr_c1_x30", rd_data_b, 64'd31);
            end
            if (cyc == 2) check("clr_c2_x0", rd_data_a, 64'd0);
            if (cyc == 10) begin
                rd_addr_a = 5'd10;
                wr_en = 1'b1; wr_addr = 5'd10; wr_data = 64'h55;
                #1;
                check("clr_wr_no_bypass", rd_data_a, 64'd11);
            end
            if (cyc == 11) begin
                wr_en = 1'b0;
                #1;
                check("clr_wr_dropped", rd_data_a, 64'd11);
            end
            if (cyc == 12) check("clr_c12_x10", rd_data_a, 64'd0);
            if (cyc == 31) check("clr_c31_x30", rd_data_b, 64'd31);
            if (cyc == 32) check("clr_c32_x30", rd_data_b, 64'd0);
            tick();
        end
        check("clr_busy_cycles", 64'(busy_n), 64'd32);
        check("clr_done_cycle", 64'(done_cyc), 64'd32);
        check("clr_done_count", 64'(done_n), 64'd1);
        check("clr_busy_after", {63'h0, clr_busy}, 64'h0);

        // asynchronous reset in cycle 10 of a clear
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 64'h99;
        tick();
        wr_en = 1'b0;
        rd_addr_a = 5'd20;
        #1;
        check("x20_before", rd_data_a, 64'h99);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (9) tick();
        check("abort_busy_before", {63'h0, clr_busy}, 64'h1);
        check("abort_x20_before", rd_data_a, 64'h99);
        #2;
        reset = 1'b1;
        #1;
        check("abort_x20", rd_data_a, 64'h0);
        check("abort_busy", {63'h0, clr_busy}, 64'h0);
        check("abort_done", {63'h0, clr_done}, 64'h0);
        tick();
        check("abort_done_held", {63'h0, clr_done}, 64'h0);
        reset = 1'b0;
        tick();
        run_clear(busy_n, done_cyc, done_n);
        check("reclr_busy_cycles", 64'(busy_n), 64'd32);
        check("reclr_done_cycle", 64'(done_cyc), 64'd32);
        check("reclr_done_count", 64'(done_n), 64'd1);

        // clr_req and wr_en together in IDLE
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'h77;
        clr_req = 1'b1;
        tick();
        wr_en = 1'b0; clr_req = 1'b0;
        rd_addr_a = 5'd2;
        #1;
        check("wrclr_c1", rd_data_a, 64'h77);
        check("wrclr_busy", {63'h0, clr_busy}, 64'h1);
        tick();
        check("wrclr_c2", rd_data_a, 64'h77);
        tick();
        check("wrclr_c3", rd_data_a, 64'h77);
        tick();
        check("wrclr_c4", rd_data_a, 64'h0);
        for (int k = 0; k < 40 && clr_busy; k++) tick();
        check("wrclr_idle", {63'h0, clr_busy}, 64'h0);

        // DEPTH=33 variant: zero index 32 and out-of-range addresses
        wr_en_v = 1'b1; wr_addr_v = 6'd32; wr_data_v = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        wr_addr_v = 6'd31; wr_data_v = 64'h31;
        tick();
        wr_addr_v = 6'd40; wr_data_v = 64'h1;
        tick();
        wr_en_v = 1'b0;
        rd_addr_a_v = 6'd32; rd_addr_b_v = 6'd31;
        #1;
        check("d33_zero_idx", rd_data_a_v, 64'h0);
        check("d33_x31", rd_data_b_v, 64'h31);
        rd_addr_a_v = 6'd40; rd_addr_b_v = 6'd63;
        #1;
        check("d33_oob_40", rd_data_a_v, 64'h0);
        check("d33_oob_63", rd_data_b_v, 64'h0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
